// File: rtl/exp_df.sv
// exp_df: WIDTH-bit ripple-borrow subtractor, diff = A - B - C, with a
// registered result stage (latency 1) and a valid flag that travels with it.
// Optional build macro: EXP_DF_COMB_OUT_EN. When it is defined the output
// registers are removed, so diff/borr follow A/B/C combinationally and
// out_valid mirrors in_valid. clk/rst_n are still ports in that build but are
// not used.
//
// Valid semantics: in_valid qualifies A/B/C on the current rising edge.
// out_valid is high for exactly one cycle per accepted input, in the cycle
// after it. There is no ready/backpressure, so a new operand set can be
// accepted on every cycle. While in_valid is low, diff/borr keep the last
// result and the operand inputs are ignored, even if they are X or Z.
module exp_df #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid
);

  // Borrow chain: w_bin[i] is the borrow into cell i. w_bin[WIDTH] is the borrow out.
  logic [WIDTH:0]   w_bin;
  logic [WIDTH-1:0] w_d;

  assign w_bin[0] = C;

  // One full-subtractor cell per bit, chained LSB to MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign w_d[gi]       = A[gi] ^ B[gi] ^ w_bin[gi];
    assign w_bin[gi + 1] = (~A[gi] & B[gi]) | (~(A[gi] ^ B[gi]) & w_bin[gi]);
  end

`ifdef EXP_DF_COMB_OUT_EN

  // Zero-latency build: the outputs are driven straight from the chain.
  assign diff      = w_d;
  assign borr      = w_bin[WIDTH];
  assign out_valid = in_valid;

`else

  logic [WIDTH-1:0] r_diff;
  logic             r_borr;
  logic             r_out_valid;

  // Result register: capture on an accepted input, otherwise hold.
  // Reset clears the result so an in-flight value is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_borr <= 1'b0;
    end else if (in_valid) begin
      r_diff <= w_d;
      r_borr <= w_bin[WIDTH];
    end
  end

  // Valid flag: a one-cycle pulse for each accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign diff      = r_diff;
  assign borr      = r_borr;
  assign out_valid = r_out_valid;

`endif

endmodule

// File: tb/tb_exp_df.sv
// tb_exp_df: checks exp_df at WIDTH 1, 8 and 16 against an arithmetic model
// (A - B - C computed with wide integers, borrow = A < B + C).
module tb_exp_df;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [0:0]  a1, b1, d1;
  logic        c1, v1, br1, ov1;
  logic [7:0]  a8, b8, d8;
  logic        c8, v8, br8, ov8;
  logic [15:0] a16, b16, d16;
  logic        c16, v16, br16, ov16;

  exp_df #(.WIDTH(1)) u_dut1 (
    .diff(d1), .borr(br1), .A(a1), .B(b1), .C(c1),
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .out_valid(ov1)
  );
  exp_df #(.WIDTH(8)) u_dut8 (
    .diff(d8), .borr(br8), .A(a8), .B(b8), .C(c8),
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .out_valid(ov8)
  );
  exp_df #(.WIDTH(16)) u_dut16 (
    .diff(d16), .borr(br16), .A(a16), .B(b16), .C(c16),
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .out_valid(ov16)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: returns {borrow, difference mod 2^w}.
  function automatic logic [32:0] ref_sub(input int w, input longint a, input longint b,
                                          input longint c);
    longint r;
    longint mask;
    logic [32:0] res;
    mask = (longint'(1) << w) - 1;
    r = a - b - c;
    res = '0;
    res[31:0] = 32'(r & mask);
    res[32] = (a < b + c);
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic v);
    a8 = a; b8 = b; c8 = c; v8 = v;
  endtask

  // Expected {diff,borr} for the WIDTH=1 sweep ABC = 000..111.
  logic [1:0] sweep_exp [8];
  initial begin
    sweep_exp[0] = 2'b00; sweep_exp[1] = 2'b11; sweep_exp[2] = 2'b11; sweep_exp[3] = 2'b01;
    sweep_exp[4] = 2'b10; sweep_exp[5] = 2'b00; sweep_exp[6] = 2'b00; sweep_exp[7] = 2'b11;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [32:0] e;
    logic [16:0] m_hold;
    logic [16:0] q;
    logic        m_ov;
    logic [2:0]  abc;

    rst_n = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0; v1 = 1'b0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    a16 = '0; b16 = '0; c16 = 1'b0; v16 = 1'b0;

`ifdef EXP_DF_COMB_OUT_EN
    rst_n = 1'b1;
    // WIDTH=1 sweep with long holds; the result must be present during each hold.
    for (int k = 0; k < 8; k++) begin
      abc = 3'(k);
      a1 = abc[2]; b1 = abc[1]; c1 = abc[0]; v1 = 1'b1;
      #100;
      check($sformatf("comb_sweep_diff_%0d", k), 32'(d1), 32'(sweep_exp[k][1]));
      check($sformatf("comb_sweep_borr_%0d", k), 32'(br1), 32'(sweep_exp[k][0]));
      check($sformatf("comb_sweep_ov_%0d", k), 32'(ov1), 32'd1);
      #100;
    end
    v1 = 1'b0; #1;
    check("comb_ov_follows", 32'(ov1), 32'd0);
    drive8(8'h00, 8'hFF, 1'b1, 1'b1); #1;
    check("comb_bnd1_diff", 32'(d8), 32'h00);
    check("comb_bnd1_borr", 32'(br8), 32'd1);
    drive8(8'h5A, 8'h5A, 1'b0, 1'b1); #1;
    check("comb_bnd2_diff", 32'(d8), 32'h00);
    check("comb_bnd2_borr", 32'(br8), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      v16 = 1'($urandom);
      #3;
      e = ref_sub(16, longint'(a16), longint'(b16), longint'(c16));
      check("comb_rand_diff", 32'(d16), 32'(e[15:0]));
      check("comb_rand_borr", 32'(br16), 32'(e[32]));
      check("comb_rand_ov", 32'(ov16), 32'(v16));
    end
`else
    // Reset state, before any clock edge.
    #2;
    check("rst_diff1", 32'(d1), 32'd0);
    check("rst_borr8", 32'(br8), 32'd0);
    check("rst_ov16", 32'(ov16), 32'd0);
    check("rst_diff8", 32'(d8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 sweep, back-to-back, one result per cycle.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("sweep_diff_%0d", k - 1), 32'(d1), 32'(sweep_exp[k - 1][1]));
        check($sformatf("sweep_borr_%0d", k - 1), 32'(br1), 32'(sweep_exp[k - 1][0]));
        check($sformatf("sweep_ov_%0d", k - 1), 32'(ov1), 32'd1);
      end
      if (k < 8) begin
        abc = 3'(k);
        a1 = abc[2]; b1 = abc[1]; c1 = abc[0]; v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
    end
    @(negedge clk);
    check("sweep_ov_drop", 32'(ov1), 32'd0);
    check("sweep_hold_diff", 32'(d1), 32'd1);

    // WIDTH=8 boundary cases.
    drive8(8'h00, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    check("bnd1_diff", 32'(d8), 32'h00);
    check("bnd1_borr", 32'(br8), 32'd1);
    drive8(8'h5A, 8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    check("bnd2_diff", 32'(d8), 32'h00);
    check("bnd2_borr", 32'(br8), 32'd0);

    // Load then hold for three idle cycles with undriven operands.
    drive8(8'h10, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check("hold_diff_0", 32'(d8), 32'h0F);
    check("hold_borr_0", 32'(br8), 32'd0);
    check("hold_ov_0", 32'(ov8), 32'd1);
    a8 = 'x; b8 = 'x; c8 = 1'bx; v8 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_diff_%0d", k), 32'(d8), 32'h0F);
      check($sformatf("hold_borr_%0d", k), 32'(br8), 32'd0);
      check($sformatf("hold_ov_%0d", k), 32'(ov8), 32'd0);
    end

    // Asynchronous reset between edges while a result is valid.
    drive8(8'h03, 8'h07, 1'b0, 1'b1);
    @(negedge clk);
    check("prerst_ov", 32'(ov8), 32'd1);
    check("prerst_diff", 32'(d8), 32'hFC);
    #2 rst_n = 1'b0;
    #1;
    check("arst_diff", 32'(d8), 32'd0);
    check("arst_borr", 32'(br8), 32'd0);
    check("arst_ov", 32'(ov8), 32'd0);
    // A valid input during reset is discarded.
    drive8(8'h44, 8'h11, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive8(8'h44, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    check("postrst_ov", 32'(ov8), 32'd0);
    check("postrst_diff", 32'(d8), 32'd0);
    drive8(8'h44, 8'h11, 1'b1, 1'b1);
    @(negedge clk);
    check("postrst_new_diff", 32'(d8), 32'h32);
    check("postrst_new_ov", 32'(ov8), 32'd1);
    v8 = 1'b0;

    // Random WIDTH=16 stream with occasional idle cycles.
    m_hold = '0;
    m_ov = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (m_ov) begin
          if (exp_q.size() == 0) begin
            check("rand_queue_empty", 32'd1, 32'd0);
          end else begin
            q = exp_q.pop_front();
            m_hold = q;
          end
        end
        check("rand_ov", 32'(ov16), 32'(m_ov));
        check("rand_diff", 32'(d16), 32'(m_hold[15:0]));
        check("rand_borr", 32'(br16), 32'(m_hold[16]));
      end
      if (i < 1000) begin
        v16 = ($urandom_range(0, 9) != 0);
        if (v16) begin
          a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
          e = ref_sub(16, longint'(a16), longint'(b16), longint'(c16));
          exp_q.push_back({e[32], e[15:0]});
        end else begin
          a16 = 'x; b16 = 'x; c16 = 1'bx;
        end
        m_ov = v16;
      end else begin
        v16 = 1'b0;
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp_df.md
EXP_DF -- requirements
Module: exp_df

Interface
REQ-001 Parameter: WIDTH, 1, operand/difference width in bits (legal 1..32).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: diff  output  WIDTH  registered difference.
REQ-005 Port: borr  output  1  registered borrow-out.
REQ-006 Port: A  input  WIDTH  minuend.
REQ-007 Port: B  input  WIDTH  subtrahend.
REQ-008 Port: C  input  1  borrow-in.
REQ-009 Port: in_valid  input  1  qualifies A/B/C this cycle.
REQ-010 Port: out_valid  output  1  diff/borr hold a fresh result.
REQ-011 Positional port order SHALL be diff, borr, A, B, C, clk, rst_n, in_valid, out_valid.

Function
REQ-012 Datapath SHALL be a ripple chain of WIDTH one-bit full-subtractor cells; cell i: d = a^b^bin, bout = (~a&b)|(~(a^b)&bin); bin of cell 0 = C; borr = bout of cell WIDTH-1.
REQ-013 Result SHALL equal A - B - C modulo 2^WIDTH; borr = 1 exactly when A < B + C (unsigned).
REQ-014 On a clk rising edge with in_valid=1, diff/borr SHALL capture the combinational result; out_valid SHALL be 1 the following cycle (latency 1).
REQ-015 On a clk rising edge with in_valid=0, diff/borr SHALL hold their value; out_valid SHALL go 0.
REQ-016 Back-to-back in_valid=1 SHALL yield one result per cycle, no bubbles; no backpressure input exists.
REQ-017 Boundary: A=0, B=2^WIDTH-1, C=1 SHALL give diff=0, borr=1; A=B, C=0 SHALL give diff=0, borr=0.
REQ-018 X/Z on inputs with in_valid=0 SHALL NOT alter any output.

Reset
REQ-019 rst_n=0 SHALL immediately (no clock needed) force diff=0, borr=0, out_valid=0.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; first result after release requires a new in_valid=1 edge.
REQ-021 Reset deassertion SHALL be synchronised by the integrator; the block adds no internal reset synchroniser.

Configuration
REQ-022 Macro EXP_DF_COMB_OUT_EN: when defined, diff/borr SHALL be driven combinationally from A/B/C (zero latency, output registers removed) and out_valid SHALL equal in_valid; clk/rst_n remain ports but are unused.
REQ-023 When EXP_DF_COMB_OUT_EN is undefined, REQ-014..REQ-020 apply (registered, latency 1).

Verification
REQ-024 WIDTH=1, registered, in_valid=1, sweep {A,B,C}=000..111 one per cycle -> next cycle {diff,borr}: 00,11,11,01,10,00,00,11.
REQ-025 WIDTH=1, EXP_DF_COMB_OUT_EN defined, same sweep with 200 ns holds, no clock -> same {diff,borr} sequence within each hold.
REQ-026 WIDTH=8, A=0x00, B=0xFF, C=1 -> diff=0x00, borr=1; A=0x5A, B=0x5A, C=0 -> diff=0x00, borr=0.
REQ-027 WIDTH=8, load A=0x10,B=0x01,C=0, then in_valid=0 for 3 cycles -> diff=0x0F held, borr=0, out_valid 1 then 0.
REQ-028 Assert rst_n=0 between clock edges while out_valid=1 -> diff=0, borr=0, out_valid=0 before next edge.
REQ-029 Random 1000 vectors WIDTH=16 -> every diff/borr matches A-B-C reference model.
